// File: rtl/register_file.sv
// register_file: eight 16-bit registers R0-R7, where R7 holds the program
// counter, plus a per-register busy (pending write) scoreboard.
// Two combinational read ports, one general write port and one dedicated R7 write port.
// Optional feature macro: RF_BYPASS_EN. When it is defined, a same-cycle write
// is forwarded to the read ports. When it is undefined, reads return stored state only.
module register_file #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  readAddr1,
    input  logic [2:0]  readAddr2,
    output logic [15:0] readData1,
    output logic [15:0] readData2,
    input  logic        regWrite,
    input  logic [2:0]  writeAddr,
    input  logic [15:0] writeData,
    input  logic        r7Write,
    input  logic [15:0] writeR7Data,
    output logic [15:0] pcOut,
    input  logic        setBusy,
    input  logic [2:0]  busyAddr,
    output logic        busy1,
    output logic        busy2
);

    logic [15:0] regs [8];
    logic [7:0]  busy;
    logic        general_write;
    logic [7:0]  set_mask;
    logic [7:0]  clear_mask;

    // The general port loses to the dedicated R7 port when both target R7
    assign general_write = regWrite && !((writeAddr == 3'd7) && r7Write);

    // Decode busy set/clear requests into one-hot masks
    always_comb begin
        set_mask   = 8'h00;
        clear_mask = 8'h00;
        if (setBusy) begin
            set_mask[busyAddr] = 1'b1;
        end
        if (regWrite) begin
            clear_mask[writeAddr] = 1'b1;
        end
        if (r7Write) begin
            clear_mask[7] = 1'b1;
        end
    end

    // Register storage: R0-R6 clear on reset, R7 loads the reset PC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) begin
                regs[i] <= 16'h0000;
            end
            regs[7] <= RESET_PC;
        end else begin
            if (general_write) begin
                regs[writeAddr] <= writeData;
            end
            if (r7Write) begin
                regs[7] <= writeR7Data;
            end
        end
    end

    // Busy vector: clear on write-back, and a set from issue overrides a same-index clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 8'h00;
        end else begin
            busy <= (busy & ~clear_mask) | set_mask;
        end
    end

    // The PC output comes straight from the R7 flop and is never forwarded
    assign pcOut = regs[7];

    // Read port 1, with optional forwarding of the writes in the current cycle
    always_comb begin
        readData1 = regs[readAddr1];
        busy1     = busy[readAddr1];
`ifdef RF_BYPASS_EN
        if (!reset) begin
            if (r7Write && (readAddr1 == 3'd7)) begin
                readData1 = writeR7Data;
                busy1     = set_mask[7];
            end else if (regWrite && (readAddr1 == writeAddr)) begin
                readData1 = writeData;
                busy1     = set_mask[readAddr1];
            end
        end
`endif
    end

    // Read port 2, with optional forwarding of the writes in the current cycle
    always_comb begin
        readData2 = regs[readAddr2];
        busy2     = busy[readAddr2];
`ifdef RF_BYPASS_EN
        if (!reset) begin
            if (r7Write && (readAddr2 == 3'd7)) begin
                readData2 = writeR7Data;
                busy2     = set_mask[7];
            end else if (regWrite && (readAddr2 == writeAddr)) begin
                readData2 = writeData;
                busy2     = set_mask[readAddr2];
            end
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file with RESET_PC = 16'h0010.
// Expected values are queued when stimulus is driven and popped when outputs are sampled.
module tb_register_file;

    localparam logic [15:0] PC0 = 16'h0010;

    logic        clk;
    logic        reset;
    logic [2:0]  readAddr1;
    logic [2:0]  readAddr2;
    logic [15:0] readData1;
    logic [15:0] readData2;
    logic        regWrite;
    logic [2:0]  writeAddr;
    logic [15:0] writeData;
    logic        r7Write;
    logic [15:0] writeR7Data;
    logic [15:0] pcOut;
    logic        setBusy;
    logic [2:0]  busyAddr;
    logic        busy1;
    logic        busy2;

    int checks;
    int failures;

    logic [15:0] exp_q [$];
    logic [15:0] m_r [8];
    logic [7:0]  m_busy;

    register_file #(.RESET_PC(PC0)) dut (
        .clk(clk),
        .reset(reset),
        .readAddr1(readAddr1),
        .readAddr2(readAddr2),
        .readData1(readData1),
        .readData2(readData2),
        .regWrite(regWrite),
        .writeAddr(writeAddr),
        .writeData(writeData),
        .r7Write(r7Write),
        .writeR7Data(writeR7Data),
        .pcOut(pcOut),
        .setBusy(setBusy),
        .busyAddr(busyAddr),
        .busy1(busy1),
        .busy2(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset state of the reference model
    function automatic void model_reset();
        for (int i = 0; i < 7; i++) m_r[i] = 16'h0000;
        m_r[7] = PC0;
        m_busy = 8'h00;
    endfunction

    // Apply one rising edge worth of writes to the reference model
    function automatic void model_edge();
        logic [7:0] nb;
        nb = m_busy;
        if (regWrite && !(writeAddr == 3'd7 && r7Write)) m_r[writeAddr] = writeData;
        if (r7Write) m_r[7] = writeR7Data;
        if (regWrite) nb[writeAddr] = 1'b0;
        if (r7Write) nb[7] = 1'b0;
        if (setBusy) nb[busyAddr] = 1'b1;
        m_busy = nb;
    endfunction

    // Value a read port should show this cycle
    function automatic logic [15:0] exp_read(input logic [2:0] a);
`ifdef RF_BYPASS_EN
        if (r7Write && a == 3'd7) return writeR7Data;
        if (regWrite && a == writeAddr) return writeData;
`endif
        return m_r[a];
    endfunction

    // Busy bit a read port should show this cycle
    function automatic logic exp_busy(input logic [2:0] a);
`ifdef RF_BYPASS_EN
        if ((r7Write && a == 3'd7) || (regWrite && a == writeAddr))
            return setBusy && (busyAddr == a);
`endif
        return m_busy[a];
    endfunction

    task automatic idle();
        regWrite = 1'b0;
        r7Write  = 1'b0;
        setBusy  = 1'b0;
    endtask

    // Advance one clock edge and sample one time unit after it
    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        reset = 1'b1;
        idle();
        writeAddr = 3'd0; writeData = 16'h0; writeR7Data = 16'h0; busyAddr = 3'd0;
        model_reset();
        #2;
        for (int i = 0; i < 8; i++) begin
            readAddr1 = 3'(i);
            readAddr2 = 3'(7 - i);
            exp_q.push_back((i == 7) ? PC0 : 16'h0000);
            exp_q.push_back((i == 0) ? PC0 : 16'h0000);
            exp_q.push_back(16'h0000);
            #1;
            e = exp_q.pop_front(); checks++;
            if (readData1 !== e) begin failures++; $display("FAIL reset_rd1[%0d]: got %h expected %h", i, readData1, e); end
            e = exp_q.pop_front(); checks++;
            if (readData2 !== e) begin failures++; $display("FAIL reset_rd2[%0d]: got %h expected %h", i, readData2, e); end
            e = exp_q.pop_front(); checks++;
            if ({busy1, busy2} !== e[1:0]) begin failures++; $display("FAIL reset_busy[%0d]: got %b%b expected 00", i, busy1, busy2); end
        end
        exp_q.push_back(PC0);
        e = exp_q.pop_front(); checks++;
        if (pcOut !== e) begin failures++; $display("FAIL reset_pc: got %h expected %h", pcOut, e); end
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        logic [15:0] e;
        regWrite = 1'b1; writeAddr = 3'd3; writeData = 16'hBEEF; readAddr1 = 3'd3;
`ifdef RF_BYPASS_EN
        exp_q.push_back(16'hBEEF);
`else
        exp_q.push_back(16'h0000);
`endif
        #1;
        e = exp_q.pop_front(); checks++;
        if (readData1 !== e) begin failures++; $display("FAIL write_same_cycle: got %h expected %h", readData1, e); end
        step();
        idle();
        exp_q.push_back(16'hBEEF);
        #1;
        e = exp_q.pop_front(); checks++;
        if (readData1 !== e) begin failures++; $display("FAIL write_next_cycle: got %h expected %h", readData1, e); end
    endtask

    task automatic test_r7_priority();
        logic [15:0] e;
        regWrite = 1'b1; writeAddr = 3'd7; writeData = 16'h1111;
        r7Write = 1'b1; writeR7Data = 16'h2222; readAddr1 = 3'd7;
        exp_q.push_back(PC0);
        exp_q.push_back(exp_read(3'd7));
        #1;
        e = exp_q.pop_front(); checks++;
        if (pcOut !== e) begin failures++; $display("FAIL pc_no_bypass: got %h expected %h", pcOut, e); end
        e = exp_q.pop_front(); checks++;
        if (readData1 !== e) begin failures++; $display("FAIL r7_same_cycle: got %h expected %h", readData1, e); end
        step();
        idle();
        exp_q.push_back(16'h2222);
        #1;
        e = exp_q.pop_front(); checks++;
        if (pcOut !== e) begin failures++; $display("FAIL r7_priority: got %h expected %h", pcOut, e); end
        regWrite = 1'b1; writeAddr = 3'd4; writeData = 16'h4444;
        r7Write = 1'b1; writeR7Data = 16'h7777; readAddr1 = 3'd4; readAddr2 = 3'd7;
        step();
        idle();
        exp_q.push_back(16'h4444);
        exp_q.push_back(16'h7777);
        #1;
        e = exp_q.pop_front(); checks++;
        if (readData1 !== e) begin failures++; $display("FAIL dual_write_r4: got %h expected %h", readData1, e); end
        e = exp_q.pop_front(); checks++;
        if (pcOut !== e) begin failures++; $display("FAIL dual_write_r7: got %h expected %h", pcOut, e); end
    endtask

    task automatic test_busy();
        logic [15:0] e;
        readAddr2 = 3'd5; readAddr1 = 3'd6;
        setBusy = 1'b1; busyAddr = 3'd5;
        step();
        idle();
        exp_q.push_back(16'h1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busy2 !== e[0]) begin failures++; $display("FAIL busy_set: got %b expected %b", busy2, e[0]); end
        regWrite = 1'b1; writeAddr = 3'd5; writeData = 16'h5555; setBusy = 1'b1; busyAddr = 3'd5;
        exp_q.push_back(16'h1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busy2 !== e[0]) begin failures++; $display("FAIL busy_set_clear_comb: got %b expected %b", busy2, e[0]); end
        step();
        idle();
        exp_q.push_back(16'h1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busy2 !== e[0]) begin failures++; $display("FAIL busy_set_wins: got %b expected %b", busy2, e[0]); end
        regWrite = 1'b1; writeAddr = 3'd5; writeData = 16'h5556;
`ifdef RF_BYPASS_EN
        exp_q.push_back(16'h0);
`else
        exp_q.push_back(16'h1);
`endif
        #1;
        e = exp_q.pop_front(); checks++;
        if (busy2 !== e[0]) begin failures++; $display("FAIL busy_clear_comb: got %b expected %b", busy2, e[0]); end
        step();
        idle();
        exp_q.push_back(16'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busy2 !== e[0]) begin failures++; $display("FAIL busy_cleared: got %b expected %b", busy2, e[0]); end
        regWrite = 1'b1; writeAddr = 3'd6; writeData = 16'h6666;
        step();
        idle();
        exp_q.push_back(16'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busy1 !== e[0]) begin failures++; $display("FAIL busy_clear_idle: got %b expected %b", busy1, e[0]); end
        readAddr1 = 3'd7; setBusy = 1'b1; busyAddr = 3'd7;
        step();
        idle();
        exp_q.push_back(16'h1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busy1 !== e[0]) begin failures++; $display("FAIL busy_r7_set: got %b expected %b", busy1, e[0]); end
        r7Write = 1'b1; writeR7Data = 16'h0100;
        step();
        idle();
        exp_q.push_back(16'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (busy1 !== e[0]) begin failures++; $display("FAIL busy_r7_clear: got %b expected %b", busy1, e[0]); end
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] e;
        readAddr1 = 3'd2; readAddr2 = 3'd2;
        setBusy = 1'b1; busyAddr = 3'd2;
        step();
        idle();
        regWrite = 1'b1; writeAddr = 3'd2; writeData = 16'h00FF;
        #2;
        reset = 1'b1;
        model_reset();
        exp_q.push_back(16'h0000);
        exp_q.push_back(PC0);
        exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front(); checks++;
        if (readData1 !== e) begin failures++; $display("FAIL reset_mid_rd: got %h expected %h", readData1, e); end
        e = exp_q.pop_front(); checks++;
        if (pcOut !== e) begin failures++; $display("FAIL reset_mid_pc: got %h expected %h", pcOut, e); end
        e = exp_q.pop_front(); checks++;
        if (busy2 !== e[0]) begin failures++; $display("FAIL reset_mid_busy: got %b expected %b", busy2, e[0]); end
        step();
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); checks++;
        if (readData1 !== e) begin failures++; $display("FAIL reset_held_rd: got %h expected %h", readData1, e); end
        @(negedge clk);
        reset = 1'b0;
        step();
        idle();
        exp_q.push_back(16'h00FF);
        #1;
        e = exp_q.pop_front(); checks++;
        if (readData1 !== e) begin failures++; $display("FAIL first_write_after_reset: got %h expected %h", readData1, e); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        for (int n = 0; n < 60; n++) begin
            regWrite    = 1'($urandom_range(0, 1));
            writeAddr   = 3'($urandom_range(0, 7));
            writeData   = 16'($urandom);
            r7Write     = ($urandom_range(0, 3) == 0);
            writeR7Data = 16'($urandom);
            setBusy     = 1'($urandom_range(0, 1));
            busyAddr    = 3'($urandom_range(0, 7));
            readAddr1   = 3'($urandom_range(0, 7));
            readAddr2   = 3'($urandom_range(0, 7));
            exp_q.push_back(exp_read(readAddr1));
            exp_q.push_back(exp_read(readAddr2));
            exp_q.push_back({14'h0, exp_busy(readAddr1), exp_busy(readAddr2)});
            exp_q.push_back(m_r[7]);
            #1;
            e = exp_q.pop_front(); checks++;
            if (readData1 !== e) begin failures++; $display("FAIL b2b_rd1[%0d]: got %h expected %h", n, readData1, e); end
            e = exp_q.pop_front(); checks++;
            if (readData2 !== e) begin failures++; $display("FAIL b2b_rd2[%0d]: got %h expected %h", n, readData2, e); end
            e = exp_q.pop_front(); checks++;
            if ({busy1, busy2} !== e[1:0]) begin failures++; $display("FAIL b2b_busy[%0d]: got %b%b expected %b", n, busy1, busy2, e[1:0]); end
            e = exp_q.pop_front(); checks++;
            if (pcOut !== e) begin failures++; $display("FAIL b2b_pc[%0d]: got %h expected %h", n, pcOut, e); end
            step();
        end
        idle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_r7_priority();
        test_busy();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
